// File: rtl/div_radix.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), BITS_PER_CYCLE quotient bits per clock; result_o = {remainder, quotient}.
// Optional `define DIV_EARLY_EXIT_EN skips leading zero dividend digits so that short dividends finish sooner.
module div_radix #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ADDR_W         = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    dividend_i,
    input  logic [WIDTH-1:0]    divisor_i,
    input  logic [2:0]          op_i,
    input  logic [ADDR_W-1:0]   reg_waddr_i,
    input  logic                start_i,
    input  logic                kill_i,
    output logic [2*WIDTH-1:0]  result_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic [2:0]          op_o,
    output logic [ADDR_W-1:0]   reg_waddr_o
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    generate
        if ((BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) ||
            (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $error("div_radix: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_quo;
    logic               neg_rem;

    logic               is_signed, a_neg, b_neg, div_zero, ovf, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   load_dvd;
    logic [CW-1:0]      load_cnt;
    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_dvd, step_quo;
    logic [WIDTH-1:0]   fix_rem, fix_quo;

    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & dividend_i[WIDTH-1];
    assign b_neg     = is_signed & divisor_i[WIDTH-1];
    assign a_mag     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign b_mag     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign ovf       = is_signed && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);
    assign accept    = start_i & ~kill_i;
    assign busy_o    = (state != IDLE);

`ifdef DIV_EARLY_EXIT_EN
    logic [CW-1:0] lz;
    logic          lz_done;

    always_comb begin
        lz      = '0;
        lz_done = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!lz_done && a_mag[i*BITS_PER_CYCLE +: BITS_PER_CYCLE] == '0) begin
                lz = lz + CW'(1);
            end else begin
                lz_done = 1'b1;
            end
        end
    end

    // A zero dividend still runs one CALC cycle so FIX always follows CALC.
    assign load_dvd = a_mag << (lz * BITS_PER_CYCLE);
    assign load_cnt = (lz == CW'(N)) ? CW'(1) : (CW'(N) - lz);
`else
    assign load_dvd = a_mag;
    assign load_cnt = CW'(N);
`endif

    always_comb begin
        step_rem = rem_q;
        step_dvd = dvd_q;
        step_quo = quo_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            step_rem = {step_rem[WIDTH-1:0], step_dvd[WIDTH-1]};
            step_dvd = {step_dvd[WIDTH-2:0], 1'b0};
            if (step_rem >= {1'b0, dvs_q}) begin
                step_rem = step_rem - {1'b0, dvs_q};
                step_quo = {step_quo[WIDTH-2:0], 1'b1};
            end else begin
                step_quo = {step_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign fix_rem = neg_rem ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    assign fix_quo = neg_quo ? (~quo_q + 1'b1) : quo_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !div_zero && !ovf) state_nxt = CALC;
            CALC: begin
                if (kill_i) begin
                    state_nxt = IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_o     <= 1'b0;
            result_o    <= '0;
            op_o        <= '0;
            reg_waddr_o <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_o        <= op_i;
                        reg_waddr_o <= reg_waddr_i;
                        if (div_zero) begin
                            result_o <= {dividend_i, {WIDTH{1'b1}}};
                            ready_o  <= 1'b1;
                        end else if (ovf) begin
                            result_o <= {{WIDTH{1'b0}}, dividend_i};
                            ready_o  <= 1'b1;
                        end else begin
                            dvd_q   <= load_dvd;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            quo_q   <= '0;
                            cnt_q   <= load_cnt;
                            neg_quo <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                        end
                    end
                end
                CALC: begin
                    if (!kill_i) begin
                        rem_q <= step_rem;
                        dvd_q <= step_dvd;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    if (!kill_i) begin
                        result_o <= {fix_rem, fix_quo};
                        ready_o  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_radix.sv
// Bench for div_radix: a B=1 instance for directed vectors and corner sequences, a B=4 instance for a random sweep.
module tb_div_radix;
    logic        clk = 1'b0;
    logic        rst, kill, start1, start4;
    logic [31:0] dividend, divisor;
    logic [2:0]  op_in;
    logic [4:0]  waddr;
    logic [63:0] res1, res4;
    logic        rdy1, rdy4, busy1, busy4;
    logic [2:0]  op1, op4;
    logic [4:0]  tag1, tag4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_radix #(.WIDTH(32), .BITS_PER_CYCLE(1), .ADDR_W(5)) dut1 (
        .clk(clk), .rst(rst), .dividend_i(dividend), .divisor_i(divisor), .op_i(op_in),
        .reg_waddr_i(waddr), .start_i(start1), .kill_i(kill), .result_o(res1), .ready_o(rdy1),
        .busy_o(busy1), .op_o(op1), .reg_waddr_o(tag1));

    div_radix #(.WIDTH(32), .BITS_PER_CYCLE(4), .ADDR_W(5)) dut4 (
        .clk(clk), .rst(rst), .dividend_i(dividend), .divisor_i(divisor), .op_i(op_in),
        .reg_waddr_i(waddr), .start_i(start4), .kill_i(kill), .result_o(res4), .ready_o(rdy4),
        .busy_o(busy4), .op_o(op4), .reg_waddr_o(tag4));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // RISC-V division semantics from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int bpc);
        int n;
        n = 32 / bpc;
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef DIV_EARLY_EXIT_EN
        begin
            int l;
            logic [31:0] m;
            l = 0;
            m = (!op[0] && a[31]) ? (32'd0 - a) : a;
            while (l < n && (m >> (32 - (l + 1) * bpc)) == 32'd0) l++;
            return (((n - l) > 1) ? (n - l) : 1) + 1;
        end
`else
        return n + 1;
`endif
    endfunction

    // Signed REM only defines the remainder half.
    function automatic logic [63:0] res_mask(input logic [2:0] op);
        return (op == 3'b110) ? {32'hFFFF_FFFF, 32'd0} : {64{1'b1}};
    endfunction

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge that raised ready_o.
    task automatic do_op(input bit use4, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [4:0] tag, input bit noise, output logic [63:0] res, output int lat,
                         output logic busy_e0, output logic [2:0] op_seen, output logic [4:0] tag_seen);
        dividend = a;
        divisor  = b;
        op_in    = op;
        waddr    = tag;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1  = 1'b0;
        start4  = 1'b0;
        busy_e0 = use4 ? busy4 : busy1;
        lat     = 0;
        while (!(use4 ? rdy4 : rdy1) && lat < 200) begin
            if (noise && $urandom_range(0, 2) == 0) begin
                dividend = $urandom;
                divisor  = $urandom;
                op_in    = 3'($urandom_range(4, 7));
                waddr    = 5'($urandom);
                if (use4) start4 = 1'b1; else start1 = 1'b1;
            end
            @(posedge clk); #1;
            start1 = 1'b0;
            start4 = 1'b0;
            lat++;
        end
        res      = use4 ? res4 : res1;
        op_seen  = use4 ? op4 : op1;
        tag_seen = use4 ? tag4 : tag1;
    endtask

    task automatic run_checked(input bit use4, input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [4:0] tag, input logic [63:0] exp, input bit noise);
        logic [63:0] res;
        int          lat, elat;
        logic        be0;
        logic [2:0]  os;
        logic [4:0]  ts;
        elat = exp_lat(a, b, op, use4 ? 4 : 1);
        do_op(use4, a, b, op, tag, noise, res, lat, be0, os, ts);
        check({name, ".result"}, res & res_mask(op), exp & res_mask(op));
        check({name, ".latency"}, 64'(lat), 64'(elat));
        check({name, ".busy"}, 64'(be0), 64'(elat != 0));
        check({name, ".op"}, 64'(os), 64'(op));
        check({name, ".tag"}, 64'(ts), 64'(tag));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [63:0] prev;
        logic        rdy_seen;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] prev;
        logic        rdy_seen;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        vecs[0]  = '{32'd100,         32'd7,         3'b101, {32'd2, 32'd14}};
        vecs[1]  = '{32'hFFFF_FFF9,   32'd2,         3'b100, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2]  = '{32'd7,           32'hFFFF_FFFE, 3'b110, {32'd1, 32'd0}};
        vecs[3]  = '{32'hFFFF_FFFF,   32'd16,        3'b111, {32'hF, 32'h0FFF_FFFF}};
        vecs[4]  = '{32'd5,           32'd0,         3'b101, {32'd5, 32'hFFFF_FFFF}};
        vecs[5]  = '{32'h8000_0000,   32'hFFFF_FFFF, 3'b100, {32'd0, 32'h8000_0000}};
        vecs[6]  = '{32'h8000_0000,   32'hFFFF_FFFF, 3'b110, {32'd0, 32'd0}};
        vecs[7]  = '{32'd1,           32'd1,         3'b101, {32'd0, 32'd1}};
        vecs[8]  = '{32'h8000_0000,   32'd3,         3'b101, {32'd2, 32'h2AAA_AAAA}};
        vecs[9]  = '{32'd0,           32'd5,         3'b100, {32'd0, 32'd0}};
        vecs[10] = '{32'hFFFF_FFFF,   32'd1,         3'b101, {32'd0, 32'hFFFF_FFFF}};
        vecs[11] = '{32'h8000_0000,   32'd2,         3'b100, {32'd0, 32'hC000_0000}};
        vecs[12] = '{32'hFFFF_FFF9,   32'd2,         3'b110, {32'hFFFF_FFFF, 32'd0}};
        vecs[13] = '{32'd3,           32'd5,         3'b111, {32'd3, 32'd0}};

        rst = 1'b1; kill = 1'b0; start1 = 1'b0; start4 = 1'b0;
        dividend = '0; divisor = '0; op_in = '0; waddr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset1", {res1, 3'(op1), 5'(tag1)}, 64'd0);
        check("reset1.ctl", 64'({rdy1, busy1}), 64'd0);
        check("reset4", {res4, 3'(op4), 5'(tag4)}, 64'd0);
        check("reset4.ctl", 64'({rdy4, busy4}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_checked(1'b0, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, 5'(i + 3), vecs[i].exp, 1'b0);
        end

        // Kill after ten CALC edges: no result, previous result kept, then a fresh request completes.
        prev = res1;
        dividend = 32'hF000_0000; divisor = 32'd3; op_in = 3'b101; waddr = 5'd17;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill.busy", 64'(busy1), 64'd0);
        rdy_seen = 1'b0;
        repeat (40) begin
            if (rdy1) rdy_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("kill.ready", 64'(rdy_seen), 64'd0);
        check("kill.result", res1, prev);
        run_checked(1'b0, "after_kill", 32'd1000, 32'd7, 3'b101, 5'd21, {32'd6, 32'd142}, 1'b0);

        // kill together with start in IDLE: request refused.
        dividend = 32'd50; divisor = 32'd5; op_in = 3'b101; waddr = 5'd1;
        start1 = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; kill = 1'b0;
        check("kill_start.busy", 64'(busy1), 64'd0);
        rdy_seen = 1'b0;
        repeat (40) begin
            if (rdy1) rdy_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("kill_start.ready", 64'(rdy_seen), 64'd0);

        // Reset mid-CALC clears every output and discards the operation.
        dividend = 32'hFFFF_0000; divisor = 32'd9; op_in = 3'b111; waddr = 5'd30;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.out", {res1, 3'(op1), 5'(tag1)}, 64'd0);
        check("midrst.ctl", 64'({rdy1, busy1}), 64'd0);
        rdy_seen = 1'b0;
        repeat (40) begin
            if (rdy1) rdy_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst.ready", 64'(rdy_seen), 64'd0);

        // Random sweeps; operand mix biases toward small, negative and degenerate divisors.
        for (int i = 0; i < 2200; i++) begin
            rop = 3'($urandom_range(4, 7));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = 32'd0 - 32'($urandom_range(1, 15));
                2:       rb = (i % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 4) == 0) ra = ra >> $urandom_range(0, 31);
            if (i < 200) begin
                run_checked(1'b0, $sformatf("rnd1_%0d", i), ra, rb, rop, 5'($urandom), ref_div(ra, rb, rop), 1'b0);
            end else begin
                run_checked(1'b1, $sformatf("rnd4_%0d", i), ra, rb, rop, 5'($urandom), ref_div(ra, rb, rop), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
